ysyx_040750_wb_sched: RTL and testbench

Write-port scheduler and scoreboard for the 32x64 integer GPR file, which has a single write port. Shares that port between the in-order pipeline writeback (P) and the long-latency unit writeback (L, mul/div and load-miss).
- Tracks a busy bit per register for outstanding L operations.
- Raises a decode hazard on RAW/WAW hits to busy registers.
- Drives the GPR write port (wen/rd/wdata) through one registered stage.

---
 rtl/ysyx_040750_wb_sched_pkg.sv | 21 ++
 rtl/ysyx_040750_scoreboard.sv | 54 +++++
 rtl/ysyx_040750_wb_sched.sv | 113 +++++++++++
 tb/tb_ysyx_040750_wb_sched.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_040750_wb_sched_pkg.sv
// Shared constants and source encoding for the GPR write-port scheduler.
// Feature macro used by the slice: YSYX_040750_WB_BYPASS_EN.
package ysyx_040750_wb_sched_pkg;

   localparam int REG_CNT = 32;
   localparam int REG_AW  = 5;
   localparam logic [REG_AW-1:0] X0 = 5'd0;

   typedef enum logic {
      SRC_P = 1'b0,
      SRC_L = 1'b1
   } src_e;

   // x0 maps to an empty mask so it can never be tracked or reported busy.
   function automatic logic [REG_CNT-1:0] reg_onehot(input logic [REG_AW-1:0] r);
      logic [REG_CNT-1:0] one;
      one = {{(REG_CNT-1){1'b0}}, 1'b1};
      reg_onehot = (r == X0) ? '0 : (one << r);
   endfunction

endpackage

// File: rtl/ysyx_040750_scoreboard.sv
// Busy-bit scoreboard: issue claims, retire clears on the L write, RAW/WAW hazard; 0-cycle hazard path.
// Issue is back-pressured while the destination is busy; YSYX_040750_WB_BYPASS_EN masks the retiring register.
module ysyx_040750_scoreboard
   import ysyx_040750_wb_sched_pkg::*;
(
   input  logic              I_sys_clk,
   input  logic              I_rst,
   input  logic              iss_vld,
   input  logic [REG_AW-1:0] iss_rd,
   output logic              iss_rdy,
   input  logic [REG_AW-1:0] dec_rs1,
   input  logic [REG_AW-1:0] dec_rs2,
   input  logic [REG_AW-1:0] dec_rd,
   input  logic              ret_vld,
   input  src_e              ret_src,
   input  logic [REG_AW-1:0] ret_rd,
`ifdef YSYX_040750_WB_BYPASS_EN
   output logic              byp_hit1,
   output logic              byp_hit2,
`endif
   output logic              hazard
);

   logic [REG_CNT-1:0] busy;
   logic [REG_CNT-1:0] set_mask;
   logic [REG_CNT-1:0] clr_mask;
   logic [REG_CNT-1:0] haz_busy;
   logic [REG_CNT-1:0] dec_mask;

   assign iss_rdy  = !busy[iss_rd] || (iss_rd == X0);
   assign set_mask = (iss_vld && iss_rdy) ? reg_onehot(iss_rd) : '0;
   // Clear coincides with the actual GPR write of an L result.
   assign clr_mask = (ret_vld && (ret_src == SRC_L)) ? reg_onehot(ret_rd) : '0;

   always_ff @(posedge I_sys_clk) begin
      if (I_rst) begin
         busy <= '0;
      end else begin
         busy <= (busy & ~clr_mask) | set_mask;
      end
   end

`ifdef YSYX_040750_WB_BYPASS_EN
   assign haz_busy = busy & ~clr_mask;
   assign byp_hit1 = (clr_mask != '0) && (dec_rs1 == ret_rd);
   assign byp_hit2 = (clr_mask != '0) && (dec_rs2 == ret_rd);
`else
   assign haz_busy = busy;
`endif

   assign dec_mask = reg_onehot(dec_rs1) | reg_onehot(dec_rs2) | reg_onehot(dec_rd);
   assign hazard   = |(haz_busy & dec_mask);

endmodule

// File: rtl/ysyx_040750_wb_sched.sv
// Shares the single GPR write port between pipeline (P) and long-unit (L) writebacks; 1-cycle registered write.
// P wins by default; after STARVE_MAX lost cycles L is forced through and P sees ready low. Bypass: YSYX_040750_WB_BYPASS_EN.
module ysyx_040750_wb_sched
   import ysyx_040750_wb_sched_pkg::*;
#(
   parameter int DATA_W     = 64,
   parameter int STARVE_MAX = 4
)
(
   input  logic              I_sys_clk,
   input  logic              I_rst,
   input  logic              I_p_valid,
   input  logic [REG_AW-1:0] I_p_rd,
   input  logic [DATA_W-1:0] I_p_data,
   output logic              O_p_ready,
   input  logic              I_l_valid,
   input  logic [REG_AW-1:0] I_l_rd,
   input  logic [DATA_W-1:0] I_l_data,
   output logic              O_l_ready,
   input  logic              I_iss_valid,
   input  logic [REG_AW-1:0] I_iss_rd,
   output logic              O_iss_ready,
   input  logic [REG_AW-1:0] I_dec_rs1,
   input  logic [REG_AW-1:0] I_dec_rs2,
   input  logic [REG_AW-1:0] I_dec_rd,
   output logic              O_hazard,
`ifdef YSYX_040750_WB_BYPASS_EN
   output logic              O_byp_hit1,
   output logic              O_byp_hit2,
   output logic [DATA_W-1:0] O_byp_data,
`endif
   output logic              O_gpr_wen,
   output logic [REG_AW-1:0] O_gpr_rd,
   output logic [DATA_W-1:0] O_gpr_wdata
);

   localparam int CNT_W = $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

   logic [CNT_W-1:0]  starve_cnt;
   logic              force_l;
   logic              l_win;
   logic              p_hs;
   logic              l_hs;
   logic [REG_AW-1:0] wb_rd;
   logic [DATA_W-1:0] wb_dat;
   logic              gpr_wen;
   logic [REG_AW-1:0] gpr_rd;
   logic [DATA_W-1:0] gpr_wdata;
   src_e              gpr_src;

   assign force_l   = (starve_cnt == STARVE_LIM);
   assign l_win     = I_l_valid && (force_l || !I_p_valid);
   assign O_l_ready = l_win;
   assign O_p_ready = !l_win;
   assign p_hs      = I_p_valid && O_p_ready;
   assign l_hs      = I_l_valid && O_l_ready;
   assign wb_rd     = l_hs ? I_l_rd   : I_p_rd;
   assign wb_dat    = l_hs ? I_l_data : I_p_data;

   always_ff @(posedge I_sys_clk) begin
      if (I_rst || !I_l_valid || l_hs) begin
         starve_cnt <= '0;
      end else if (!force_l) begin
         starve_cnt <= starve_cnt + CNT_W'(1);
      end
   end

   // x0 handshakes are consumed but never reach the write port.
   always_ff @(posedge I_sys_clk) begin
      if (I_rst) begin
         gpr_wen   <= 1'b0;
         gpr_rd    <= X0;
         gpr_wdata <= '0;
         gpr_src   <= SRC_P;
      end else if (p_hs || l_hs) begin
         gpr_wen   <= (wb_rd != X0);
         gpr_rd    <= wb_rd;
         gpr_wdata <= wb_dat;
         gpr_src   <= l_hs ? SRC_L : SRC_P;
      end else begin
         gpr_wen   <= 1'b0;
      end
   end

   assign O_gpr_wen   = gpr_wen;
   assign O_gpr_rd    = gpr_rd;
   assign O_gpr_wdata = gpr_wdata;

`ifdef YSYX_040750_WB_BYPASS_EN
   assign O_byp_data = gpr_wdata;
`endif

   ysyx_040750_scoreboard u_scoreboard (
      .I_sys_clk (I_sys_clk),
      .I_rst     (I_rst),
      .iss_vld   (I_iss_valid),
      .iss_rd    (I_iss_rd),
      .iss_rdy   (O_iss_ready),
      .dec_rs1   (I_dec_rs1),
      .dec_rs2   (I_dec_rs2),
      .dec_rd    (I_dec_rd),
      .ret_vld   (gpr_wen),
      .ret_src   (gpr_src),
      .ret_rd    (gpr_rd),
`ifdef YSYX_040750_WB_BYPASS_EN
      .byp_hit1  (O_byp_hit1),
      .byp_hit2  (O_byp_hit2),
`endif
      .hazard    (O_hazard)
   );

endmodule

// File: tb/tb_ysyx_040750_wb_sched.sv
// Table-driven bench for ysyx_040750_wb_sched with a queue of expected write-port beats.
// Handles both builds of YSYX_040750_WB_BYPASS_EN.
module tb_ysyx_040750_wb_sched;

   logic        clk = 1'b0;
   logic        rst;
   logic        p_valid, l_valid, iss_valid;
   logic [4:0]  p_rd, l_rd, iss_rd, dec_rs1, dec_rs2, dec_rd;
   logic [63:0] p_data, l_data;
   logic        p_ready, l_ready, iss_ready, hazard, gpr_wen;
   logic [4:0]  gpr_rd;
   logic [63:0] gpr_wdata;
`ifdef YSYX_040750_WB_BYPASS_EN
   logic        byp_hit1, byp_hit2;
   logic [63:0] byp_data;
`endif

   always #5 clk = ~clk;

   ysyx_040750_wb_sched #(.DATA_W(64), .STARVE_MAX(4)) dut (
      .I_sys_clk   (clk),
      .I_rst       (rst),
      .I_p_valid   (p_valid),
      .I_p_rd      (p_rd),
      .I_p_data    (p_data),
      .O_p_ready   (p_ready),
      .I_l_valid   (l_valid),
      .I_l_rd      (l_rd),
      .I_l_data    (l_data),
      .O_l_ready   (l_ready),
      .I_iss_valid (iss_valid),
      .I_iss_rd    (iss_rd),
      .O_iss_ready (iss_ready),
      .I_dec_rs1   (dec_rs1),
      .I_dec_rs2   (dec_rs2),
      .I_dec_rd    (dec_rd),
      .O_hazard    (hazard),
`ifdef YSYX_040750_WB_BYPASS_EN
      .O_byp_hit1  (byp_hit1),
      .O_byp_hit2  (byp_hit2),
      .O_byp_data  (byp_data),
`endif
      .O_gpr_wen   (gpr_wen),
      .O_gpr_rd    (gpr_rd),
      .O_gpr_wdata (gpr_wdata)
   );

   typedef struct {
      logic        pv;  logic [4:0] prd; logic [63:0] pdat;
      logic        lv;  logic [4:0] lrd; logic [63:0] ldat;
      logic        iv;  logic [4:0] ird;
      logic [4:0]  rs1; logic [4:0] rs2; logic [4:0] drd;
      logic        epr; logic elr; logic eir;
      logic        ehz; logic ehzb; logic eb1;
   } vec_t;

   typedef struct {
      logic        wen;
      logic [4:0]  rd;
      logic [63:0] dat;
   } wb_t;

   vec_t vecs[$];
   wb_t  exp_q[$];
   int   n_chk  = 0;
   int   n_pass = 0;

   function automatic vec_t mk(
      input logic pv, input logic [4:0] prd, input logic [63:0] pdat,
      input logic lv, input logic [4:0] lrd, input logic [63:0] ldat,
      input logic iv, input logic [4:0] ird,
      input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] drd,
      input logic epr, input logic elr, input logic eir,
      input logic ehz, input logic ehzb, input logic eb1);
      vec_t v;
      v.pv = pv; v.prd = prd; v.pdat = pdat;
      v.lv = lv; v.lrd = lrd; v.ldat = ldat;
      v.iv = iv; v.ird = ird;
      v.rs1 = rs1; v.rs2 = rs2; v.drd = drd;
      v.epr = epr; v.elr = elr; v.eir = eir;
      v.ehz = ehz; v.ehzb = ehzb; v.eb1 = eb1;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // One clock: registered outputs are compared #1 after the edge against the queued beat.
   task automatic tick(input string tag);
      wb_t e;
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         n_chk++;
         $display("FAIL %s.wb_queue: got empty expected entry", tag);
      end else begin
         e = exp_q.pop_front();
         chk({tag, ".gpr_wen"}, {63'd0, gpr_wen}, {63'd0, e.wen});
         if (e.wen) begin
            chk({tag, ".gpr_rd"}, {59'd0, gpr_rd}, {59'd0, e.rd});
            chk({tag, ".gpr_wdata"}, gpr_wdata, e.dat);
         end
      end
      @(negedge clk);
   endtask

   task automatic apply(input vec_t v, input int idx);
      wb_t e;
      string tag;
      tag = $sformatf("vec%0d", idx);
      p_valid = v.pv; p_rd = v.prd; p_data = v.pdat;
      l_valid = v.lv; l_rd = v.lrd; l_data = v.ldat;
      iss_valid = v.iv; iss_rd = v.ird;
      dec_rs1 = v.rs1; dec_rs2 = v.rs2; dec_rd = v.drd;
      #1;
      chk({tag, ".p_ready"},   {63'd0, p_ready},   {63'd0, v.epr});
      chk({tag, ".l_ready"},   {63'd0, l_ready},   {63'd0, v.elr});
      chk({tag, ".iss_ready"}, {63'd0, iss_ready}, {63'd0, v.eir});
`ifdef YSYX_040750_WB_BYPASS_EN
      chk({tag, ".hazard"},    {63'd0, hazard},    {63'd0, v.ehzb});
      chk({tag, ".byp_hit1"},  {63'd0, byp_hit1},  {63'd0, v.eb1});
      // ldat of a bypass row carries the expected forwarded value.
      if (v.eb1) chk({tag, ".byp_data"}, byp_data, v.ldat);
`else
      chk({tag, ".hazard"},    {63'd0, hazard},    {63'd0, v.ehz});
`endif
      if (v.lv && v.elr)      begin e.wen = (v.lrd != 5'd0); e.rd = v.lrd; e.dat = v.ldat; end
      else if (v.pv && v.epr) begin e.wen = (v.prd != 5'd0); e.rd = v.prd; e.dat = v.pdat; end
      else                    begin e.wen = 1'b0; e.rd = 5'd0; e.dat = '0; end
      exp_q.push_back(e);
      tick(tag);
   endtask

   initial begin
      logic any_haz, all_iss;

      // P only
      for (int i = 0; i < 3; i++)
         vecs.push_back(mk(1,5,64'hA5, 0,0,0, 0,0, 0,0,0, 1,0,1, 0,0,0));
      // Issue rd=10, RAW hazard, L writeback of 0x1234, retire
      vecs.push_back(mk(0,0,0, 0,0,0,        1,10,  0,0,0, 1,0,1, 0,0,0));
      vecs.push_back(mk(0,0,0, 0,0,0,        0,10, 10,0,0, 1,0,0, 1,1,0));
      vecs.push_back(mk(0,0,0, 1,10,64'h1234, 0,10, 10,0,0, 0,1,0, 1,1,0));
      vecs.push_back(mk(0,0,0, 0,0,64'h1234, 0,10, 10,0,0, 1,0,0, 1,0,1));
      vecs.push_back(mk(0,0,0, 0,0,0,        0,10, 10,0,0, 1,0,1, 0,0,0));
      // Contention: P wins four cycles, L forced on the fifth, counter restarts
      for (int i = 0; i < 4; i++)
         vecs.push_back(mk(1,6,64'h100 + 64'(i), 1,11,64'h77, 0,0, 0,0,0, 1,0,1, 0,0,0));
      vecs.push_back(mk(1,6,64'h200, 1,11,64'h77, 0,0, 0,0,0, 0,1,1, 0,0,0));
      vecs.push_back(mk(1,6,64'h201, 1,11,64'h78, 0,0, 0,0,0, 1,0,1, 0,0,0));
      vecs.push_back(mk(0,0,0, 0,0,0, 0,0, 0,0,0, 1,0,1, 0,0,0));
      // x0 guard
      vecs.push_back(mk(0,0,0, 1,0,64'h55, 1,0, 0,0,0, 0,1,1, 0,0,0));
      vecs.push_back(mk(0,0,0, 0,0,0,      1,0, 0,0,0, 1,0,1, 0,0,0));
      // Double claim on rd=7, WAW hazard, reclaim after retire
      vecs.push_back(mk(0,0,0, 0,0,0,        1,7, 0,0,0, 1,0,1, 0,0,0));
      vecs.push_back(mk(0,0,0, 0,0,0,        1,7, 0,0,7, 1,0,0, 1,1,0));
      vecs.push_back(mk(0,0,0, 1,7,64'h7777, 1,7, 0,0,7, 0,1,0, 1,1,0));
      vecs.push_back(mk(0,0,0, 0,0,0,        1,7, 0,0,7, 1,0,0, 1,0,0));
      vecs.push_back(mk(0,0,0, 0,0,0,        1,7, 0,0,7, 1,0,1, 0,0,0));
      vecs.push_back(mk(0,0,0, 0,0,0,        0,0, 0,7,0, 1,0,1, 1,1,0));
      // Claim 3 and 9 ahead of the reset sequence
      vecs.push_back(mk(0,0,0, 0,0,0, 1,3, 0,0,0, 1,0,1, 0,0,0));
      vecs.push_back(mk(0,0,0, 0,0,0, 1,9, 0,0,0, 1,0,1, 0,0,0));
      vecs.push_back(mk(0,0,0, 0,0,0, 0,0, 3,9,0, 1,0,1, 1,1,0));

      rst = 1'b1;
      p_valid = 0; p_rd = 0; p_data = 0;
      l_valid = 0; l_rd = 0; l_data = 0;
      iss_valid = 0; iss_rd = 0;
      dec_rs1 = 0; dec_rs2 = 0; dec_rd = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("reset.gpr_wen",   {63'd0, gpr_wen}, 64'd0);
      chk("reset.gpr_rd",    {59'd0, gpr_rd},  64'd0);
      chk("reset.gpr_wdata", gpr_wdata,        64'd0);
      chk("reset.p_ready",   {63'd0, p_ready}, 64'd1);
      any_haz = 1'b0;
      all_iss = 1'b1;
      for (int r = 1; r < 32; r++) begin
         dec_rs1 = 5'(r); iss_rd = 5'(r);
         #1;
         any_haz |= hazard;
         all_iss &= iss_ready;
      end
      dec_rs1 = 0; iss_rd = 0;
      chk("reset.no_busy_hazard", {63'd0, any_haz}, 64'd0);
      chk("reset.all_iss_ready",  {63'd0, all_iss}, 64'd1);
      @(negedge clk);

      for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

      // Reset while an L beat to rd=9 is being accepted: the beat is dropped.
      rst = 1'b1;
      l_valid = 1; l_rd = 5'd9; l_data = 64'h99;
      iss_valid = 0; dec_rs1 = 0; dec_rs2 = 0; dec_rd = 0;
      exp_q.push_back('{wen: 1'b0, rd: 5'd0, dat: 64'd0});
      tick("rst_mid");
      rst = 1'b0;
      l_valid = 0; l_rd = 0; l_data = 0;
      dec_rs1 = 5'd3; dec_rs2 = 5'd9; dec_rd = 5'd7; iss_rd = 5'd3;
      #1;
      chk("rst_mid.gpr_rd",    {59'd0, gpr_rd},    64'd0);
      chk("rst_mid.gpr_wdata", gpr_wdata,          64'd0);
      chk("rst_mid.hazard",    {63'd0, hazard},    64'd0);
      chk("rst_mid.iss_ready", {63'd0, iss_ready}, 64'd1);
      exp_q.push_back('{wen: 1'b0, rd: 5'd0, dat: 64'd0});
      tick("rst_after");
      chk("rst_after.hazard",  {63'd0, hazard},    64'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
